// File: rtl/risc16_uart_mmio.sv
// risc16_uart_mmio
//   Memory-mapped 8N1 UART transmitter on the risc16f data bus. It decodes an
//   8-byte register window at IO_BASE, queues byte writes into a TX FIFO and
//   serialises them LSB first on txd. Reads are combinational, so the top level
//   can mux io_rdata onto the core's ddin whenever io_sel is high.
//
//   Optional feature: define RISC16_UART_PARITY_EN to insert a parity bit
//   between the data bits and the stop bit. The bit is even parity, or odd
//   parity when CTRL.par_odd=1, and the frame grows to 11 bits. Without the
//   macro the frame is 10 bits and CTRL bit 2 is not writable and reads 0.
//
// Register map (offset = daddr[2:1]):
//   0 TXDATA  W: push ddout[7:0]          R: 0
//   1 STATUS  R: {count[7:0], 4'h0, ovf, busy, empty, full}
//             W: ddout[3]=1 clears the sticky ovf flag
//   2 BAUDDIV R/W: bit time = BAUDDIV+1 clk cycles, sampled at each bit start
//   3 CTRL    R/W: {par_odd, irq_en, tx_en}
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   daddr      core data byte address (bit 0 ignored)
//   ddout      core write data
//   doe, dwe   core read / write strobes
//   io_sel     comb: daddr falls inside the register window
//   io_rdata   comb read data, 0 unless io_sel & doe
//   txd        serial output, idle high (registered)
//   irq        registered level interrupt: irq_en & FIFO empty & transmitter idle
module risc16_uart_mmio #(
  parameter logic [15:0] IO_BASE     = 16'hFF00,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] daddr,
  input  logic [15:0] ddout,
  input  logic        doe,
  input  logic        dwe,
  output logic        io_sel,
  output logic [15:0] io_rdata,
  output logic        txd,
  output logic        irq
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_t;

  // Bus decode
  logic [1:0] reg_off;
  logic       wr_en;
  assign io_sel  = (daddr[15:3] == IO_BASE[15:3]);
  assign reg_off = daddr[2:1];
  assign wr_en   = dwe & io_sel;

  // Registers
  logic [15:0] baud_div;
  logic        tx_en;
  logic        irq_en;
  logic        par_odd;
  logic        ovf;

  // FIFO
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          push_ok;
  logic          pop;

  // Transmitter
  tx_state_t   state;
  logic [15:0] baud_cnt;
  logic [15:0] bit_div;   // divisor latched at the start of the current bit
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic        busy;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign push    = wr_en & (reg_off == 2'd0);
  // Full is judged on the count at the start of the cycle, so a push into a
  // full FIFO is dropped even if the transmitter pops in the same cycle.
  assign push_ok = push & ~full;
  assign busy    = (state != S_IDLE);
  assign pop     = (state == S_IDLE) & tx_en & ~empty;

  // Status count is reported as 8 bits regardless of FIFO depth.
  logic [8:0] count_ext;
  assign count_ext = 9'(count);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= ddout[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      baud_div <= DEFAULT_DIV;
      tx_en    <= 1'b0;
      irq_en   <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (push & full) begin
        ovf <= 1'b1;
      end else if (wr_en && reg_off == 2'd1 && ddout[3]) begin
        ovf <= 1'b0;
      end

      if (wr_en && reg_off == 2'd2) begin
        baud_div <= ddout;
      end
      if (wr_en && reg_off == 2'd3) begin
        tx_en  <= ddout[0];
        irq_en <= ddout[1];
      end
    end
  end

`ifdef RISC16_UART_PARITY_EN
  logic par_odd_q;
  logic par_bit;
  assign par_odd = par_odd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      par_odd_q <= 1'b0;
    end else if (wr_en && reg_off == 2'd3) begin
      par_odd_q <= ddout[2];
    end
  end
`else
  assign par_odd = 1'b0;
`endif

  // TX FSM. txd is registered and always takes the value of the bit that the
  // state being entered transmits, so there is no combinational glitch on txd.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      txd      <= 1'b1;
      baud_cnt <= '0;
      bit_div  <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
`ifdef RISC16_UART_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else if (state == S_IDLE) begin
      txd <= 1'b1;
      if (pop) begin
        shift    <= fifo_mem[rd_ptr];
`ifdef RISC16_UART_PARITY_EN
        par_bit  <= (^fifo_mem[rd_ptr]) ^ par_odd;
`endif
        txd      <= 1'b0;
        baud_cnt <= '0;
        bit_div  <= baud_div;
        state    <= S_START;
      end
    end else if (baud_cnt != bit_div) begin
      baud_cnt <= baud_cnt + 16'd1;
    end else begin
      // Bit boundary: pick up any new divisor for the next bit.
      baud_cnt <= '0;
      bit_div  <= baud_div;
      case (state)
        S_START: begin
          txd     <= shift[0];
          bit_cnt <= '0;
          state   <= S_DATA;
        end
        S_DATA: begin
          if (bit_cnt == 3'd7) begin
`ifdef RISC16_UART_PARITY_EN
            txd   <= par_bit;
            state <= S_PARITY;
`else
            txd   <= 1'b1;
            state <= S_STOP;
`endif
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            shift   <= {1'b0, shift[7:1]};
            txd     <= shift[1];
          end
        end
        S_PARITY: begin
          txd   <= 1'b1;
          state <= S_STOP;
        end
        default: begin
          txd   <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq <= 1'b0;
    end else begin
      irq <= irq_en & empty & ~busy;
    end
  end

  always_comb begin
    io_rdata = 16'h0000;
    if (io_sel & doe) begin
      case (reg_off)
        2'd1:    io_rdata = {count_ext[7:0], 4'h0, ovf, busy, empty, full};
        2'd2:    io_rdata = baud_div;
        2'd3:    io_rdata = {13'h0000, par_odd, irq_en, tx_en};
        default: io_rdata = 16'h0000;
      endcase
    end
  end

  // Address bit 0 and unreported count bits are intentionally ignored.
  logic unused_bits;
`ifdef RISC16_UART_PARITY_EN
  assign unused_bits = ^{daddr[0], count_ext[8]};
`else
  assign unused_bits = ^{daddr[0], count_ext[8], ddout[2]};
`endif

endmodule

// File: tb/tb_risc16_uart_mmio.sv
// Bench for risc16_uart_mmio: bus driver tasks, a txd frame monitor that pops
// expected bytes from a scoreboard queue, directed waveform/status checks and
// a final one-line report.
module tb_risc16_uart_mmio;

  localparam logic [15:0] A_TX  = 16'hFF00;
  localparam logic [15:0] A_ST  = 16'hFF02;
  localparam logic [15:0] A_BD  = 16'hFF04;
  localparam logic [15:0] A_CT  = 16'hFF06;
  localparam logic [15:0] A_BAD = 16'hFEFE;

`ifdef RISC16_UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] daddr;
  logic [15:0] ddout;
  logic        doe;
  logic        dwe;
  logic        io_sel;
  logic [15:0] io_rdata;
  logic        txd;
  logic        irq;

  risc16_uart_mmio dut (
    .clk      (clk),
    .rst      (rst),
    .daddr    (daddr),
    .ddout    (ddout),
    .doe      (doe),
    .dwe      (dwe),
    .io_sel   (io_sel),
    .io_rdata (io_rdata),
    .txd      (txd),
    .irq      (irq)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard
  logic [7:0] exp_q[$];

  // Monitor configuration, only changed while the line is idle.
  int   mon_div     = 433;
  logic mon_par_odd = 1'b0;
  int   mon_frames  = 0;

  logic       mon_active = 1'b0;
  int         mon_cnt    = 0;
  int         mon_idx    = 0;
  logic [7:0] mon_data   = 8'h00;
  logic       mon_par    = 1'b0;
  logic [7:0] mon_exp    = 8'h00;

  // Frame monitor: samples each bit at its first cycle, counted from the
  // first low sample of the start bit.
  always @(negedge clk) begin
    if (rst) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (txd == 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt % (mon_div + 1) == 0) begin
        mon_idx = mon_cnt / (mon_div + 1);
        if (mon_idx >= 1 && mon_idx <= 8) begin
          mon_data[mon_idx-1] = txd;
        end else if (mon_idx == FRAME_BITS - 1) begin
          check("stop_bit", txd, 1);
          mon_frames++;
          check("frame_queued", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            check("frame_data", mon_data, mon_exp);
`ifdef RISC16_UART_PARITY_EN
            check("frame_parity", mon_par, (^mon_exp) ^ mon_par_odd);
`endif
          end
          mon_active = 1'b0;
        end else begin
          mon_par = txd;
        end
      end
    end
  end

  // Driver tasks: start and end on a falling edge.
  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    daddr = a;
    ddout = d;
    dwe   = 1'b1;
    @(negedge clk);
    dwe   = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    daddr = a;
    doe   = 1'b1;
    #1;
    d     = io_rdata;
    doe   = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    exp_q.push_back(b);
    bus_write(A_TX, {8'h00, b});
  endtask

  task automatic wait_drain(input int bound);
    logic [15:0] st;
    logic        done;
    done = 1'b0;
    for (int i = 0; i < bound; i++) begin
      bus_read(A_ST, st);
      if (st[1] && !st[2] && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("drain_in_time", done, 1);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog got=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [15:0] rd;
    logic        exp_txd;
    logic        seen_busy;
    logic        gap_done;
    int          errs;
    int          busy_cycles;
    int          gaps;
    int          irq_hi;
    int          frames0;
    logic [7:0]  b55;

    rst = 1'b1; daddr = 16'h0; ddout = 16'h0; doe = 1'b0; dwe = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_txd", txd, 1);
    check("rst_irq", irq, 0);
    bus_read(A_ST, rd); check("rst_status", rd, 16'h0002);
    bus_read(A_BD, rd); check("rst_bauddiv", rd, 16'd433);
    bus_read(A_CT, rd); check("rst_ctrl", rd, 16'h0000);
    bus_read(A_TX, rd); check("txdata_reads_0", rd, 16'h0000);

    // 1: single frame of 0x55 at BAUDDIV=3
    bus_write(A_BD, 16'd3); mon_div = 3;
    bus_write(A_CT, 16'h0001);
    b55 = 8'h55;
    send_byte(b55);
    check("t1_idle_before_start", txd, 1);
    errs = 0; busy_cycles = 0;
    for (int k = 1; k <= FRAME_BITS * 4 + 4; k++) begin
      @(negedge clk);
      if (k <= 4) exp_txd = 1'b0;
      else if (k <= 36) exp_txd = b55[(k-5)/4];
`ifdef RISC16_UART_PARITY_EN
      else if (k <= 40) exp_txd = ^b55;
`endif
      else exp_txd = 1'b1;
      if (txd !== exp_txd) errs++;
      bus_read(A_ST, rd);
      if (k == 1) check("t1_status_after_pop", rd, 16'h0006);
      busy_cycles += int'(rd[2]);
    end
    check("t1_wave_errors", errs, 0);
    check("t1_busy_cycles", busy_cycles, FRAME_BITS * 4);

    // 2: overflow with transmitter disabled, then back-to-back drain
    bus_write(A_CT, 16'h0000);
    for (int i = 0; i < 8; i++) send_byte(8'($urandom_range(0, 255)));
    bus_write(A_TX, 16'h00AA);
    bus_read(A_ST, rd); check("t2_status_full_ovf", rd, 16'h0809);
    bus_write(A_ST, 16'h0008);
    bus_read(A_ST, rd); check("t2_ovf_cleared", rd, 16'h0801);
    frames0 = mon_frames;
    bus_write(A_CT, 16'h0001);
    seen_busy = 1'b0; gap_done = 1'b0; gaps = 0;
    for (int i = 0; i < 1000; i++) begin
      bus_read(A_ST, rd);
      if (rd[2]) seen_busy = 1'b1;
      else if (seen_busy) begin
        if (rd[1]) begin
          gap_done = 1'b1;
          break;
        end
        gaps++;
      end
      @(negedge clk);
    end
    check("t2_drained_in_time", gap_done, 1);
    check("t2_idle_gap_cycles", gaps, 7);
    repeat (60) @(negedge clk);
    check("t2_frames_sent", mon_frames - frames0, 8);
    check("t2_queue_empty", exp_q.size(), 0);

    // 3: irq timing at BAUDDIV=0
    bus_write(A_BD, 16'd0); mon_div = 0;
    bus_write(A_CT, 16'h0003);
    bus_read(A_CT, rd); check("t3_ctrl_read", rd, 16'h0003);
    send_byte(8'hA3);
    check("t3_irq_before", irq, 1);
    irq_hi = 0;
    for (int k = 1; k <= FRAME_BITS + 1; k++) begin
      @(negedge clk);
      irq_hi += int'(irq);
    end
    check("t3_irq_low_in_frame", irq_hi, 0);
    @(negedge clk);
    check("t3_irq_after_stop", irq, 1);
    wait_drain(50);

    // 4: reset in the middle of data bit 4
    bus_write(A_BD, 16'd3); mon_div = 3;
    bus_write(A_CT, 16'h0001);
    bus_write(A_TX, 16'h000F);
    for (int k = 1; k <= 21; k++) @(negedge clk);
    check("t4_bit4_low", txd, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("t4_txd_high", txd, 1);
    check("t4_irq_low", irq, 0);
    bus_read(A_ST, rd); check("t4_status", rd, 16'h0002);
    bus_read(A_BD, rd); check("t4_bauddiv", rd, 16'd433);
    bus_read(A_CT, rd); check("t4_ctrl", rd, 16'h0000);

    // 5: parity / frame length, plus a few random bytes
    bus_write(A_BD, 16'd1); mon_div = 1;
`ifdef RISC16_UART_PARITY_EN
    bus_write(A_CT, 16'h0001); mon_par_odd = 1'b0;
    send_byte(8'h07);
    wait_drain(200);
    bus_write(A_CT, 16'h0005); mon_par_odd = 1'b1;
    bus_read(A_CT, rd); check("t5_ctrl_par_odd", rd, 16'h0005);
    send_byte(8'h07);
    wait_drain(200);
`else
    bus_write(A_CT, 16'h0007);
    bus_read(A_CT, rd); check("t5_ctrl_bit2_ignored", rd, 16'h0003);
    send_byte(8'h07);
    wait_drain(200);
`endif
    for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 255)));
    wait_drain(500);

    // 6: accesses just below the window
    daddr = A_BAD; doe = 1'b1;
    #1;
    check("t6_io_sel_out", io_sel, 0);
    check("t6_rdata_out", io_rdata, 16'h0000);
    doe = 1'b0;
    bus_write(A_BAD, 16'h1234);
    bus_read(A_BD, rd); check("t6_bauddiv_kept", rd, 16'd1);
    bus_read(A_ST, rd); check("t6_status_kept", rd, 16'h0002);
    daddr = A_CT; doe = 1'b0;
    #1;
    check("t6_io_sel_in", io_sel, 1);
    check("t6_rdata_no_doe", io_rdata, 16'h0000);

    repeat (5) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
